// File: rtl/pong_disp_pkg.sv
// -----------------------------------------------------------------------------
// pong_disp_pkg
// Shared constants and types for the multiplexed 7-segment score display.
//   SLOT_R / SLOT_L / SLOT_DARK : decoder digit-select codes
//   NUM_BLANK                   : decoder value that renders as a dash / blank
//   mode_e                      : score display mode (steady or winner blink)
//   fmt_digit()                 : maps out-of-range scores (> 9) to NUM_BLANK
// -----------------------------------------------------------------------------
package pong_disp_pkg;

  localparam logic [1:0] SLOT_R    = 2'd0;
  localparam logic [1:0] SLOT_L    = 2'd2;
  localparam logic [1:0] SLOT_DARK = 2'd1;

  localparam logic [3:0] NUM_BLANK = 4'hF;

  typedef enum logic {
    SHOW  = 1'b0,
    BLINK = 1'b1
  } mode_e;

  function automatic logic [3:0] fmt_digit(input logic [3:0] v);
    return (v > 4'd9) ? NUM_BLANK : v;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Free-running slot timer for a 4-slot multiplexed display.
//   clk_i        : clock
//   rst_i        : asynchronous active-high reset
//   slot_o       : current slot index 0..3
//   slot_adv_o   : high in the last cycle of a slot (prescaler wraps next edge)
//   frame_tick_o : one-cycle pulse in the first cycle of slot 0 of each frame
// -----------------------------------------------------------------------------
module scan_prescaler #(
  parameter int SLOT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [1:0] slot_o,
  output logic       slot_adv_o,
  output logic       frame_tick_o
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic             tick_q, tick_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    slot_d = wrap ? slot_q + 2'd1 : slot_q;
    // Registered so the pulse lines up with the cycle slot_q becomes 0;
    // a reset never produces a tick because tick_q clears to 0.
    tick_d = wrap && (slot_q == 2'd3);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      slot_q <= 2'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      tick_q <= tick_d;
    end
  end

  assign slot_o       = slot_q;
  assign slot_adv_o   = wrap;
  assign frame_tick_o = tick_q;

endmodule

// File: rtl/score_scan_ctrl.sv
// -----------------------------------------------------------------------------
// score_scan_ctrl
// Time-multiplexing controller feeding the combinational 7-segment decoder.
// Holds both player scores with frame-boundary (tear-free) updates, scans the
// four digit slots and flashes the winner's digit after game over.
//   clk, reset           : clock, asynchronous active-high reset
//   score_l / score_r    : new score pair, valid with score_upd
//   score_upd            : strobe, captures a pending score pair
//   game_over, winner_l  : strobe + winner (1 = left) -> start blinking
//   game_restart         : strobe, clears scores and blinking
//   digit_sel, digit_num : registered decoder en / num
//   frame_tick           : one-cycle pulse at each frame start
// -----------------------------------------------------------------------------
module score_scan_ctrl
  import pong_disp_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] score_l,
  input  logic [3:0] score_r,
  input  logic       score_upd,
  input  logic       game_over,
  input  logic       winner_l,
  input  logic       game_restart,
  output logic [1:0] digit_sel,
  output logic [3:0] digit_num,
  output logic       frame_tick
);

  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(BLINK_FRAMES - 1);

  logic [1:0] slot;
  logic       slot_adv;
  logic       tick;

  scan_prescaler #(
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_scan (
    .clk_i        (clk),
    .rst_i        (reset),
    .slot_o       (slot),
    .slot_adv_o   (slot_adv),
    .frame_tick_o (tick)
  );

  logic [3:0]      disp_l_q, disp_l_d, disp_r_q, disp_r_d;
  logic [3:0]      pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic            pflag_q, pflag_d;
  mode_e           mode_q, mode_d;
  logic            win_l_q, win_l_d;
  logic            hidden_q, hidden_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      num_q, num_d;
  logic            blank_l, blank_r;

  // Score latch: display registers only change at a frame boundary.
  always_comb begin
    disp_l_d = disp_l_q;
    disp_r_d = disp_r_q;
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    pflag_d  = pflag_q;
    if (game_restart) begin
      disp_l_d = 4'd0;
      disp_r_d = 4'd0;
      pend_l_d = 4'd0;
      pend_r_d = 4'd0;
      pflag_d  = 1'b0;
    end else begin
      if (tick && pflag_q) begin
        disp_l_d = pend_l_q;
        disp_r_d = pend_r_q;
        pflag_d  = 1'b0;
      end
      // Applied after the load so a coincident update becomes the next pending pair.
      if (score_upd) begin
        pend_l_d = score_l;
        pend_r_d = score_r;
        pflag_d  = 1'b1;
      end
    end
  end

  // Blink FSM next state.
  always_comb begin
    mode_d   = mode_q;
    win_l_d  = win_l_q;
    hidden_d = hidden_q;
    fc_d     = fc_q;
    if (game_restart) begin
      mode_d   = SHOW;
      hidden_d = 1'b0;
      fc_d     = '0;
    end else if (game_over) begin
      mode_d   = BLINK;
      win_l_d  = winner_l;
      hidden_d = 1'b0;
      fc_d     = '0;
    end else begin
      case (mode_q)
        BLINK: begin
          if (tick) begin
            if (fc_q == FC_MAX) begin
              fc_d     = '0;
              hidden_d = ~hidden_q;
            end else begin
              fc_d = fc_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output mapping uses next-state score/blink values so the first slot-0
  // of a new frame already reflects the frame-boundary load.
  always_comb begin
    blank_l = (mode_d == BLINK) && hidden_d && win_l_d;
    blank_r = (mode_d == BLINK) && hidden_d && !win_l_d;
    sel_d   = slot;
    num_d   = NUM_BLANK;
    case (slot)
      SLOT_R: begin
        sel_d = blank_r ? SLOT_DARK : SLOT_R;
        num_d = blank_r ? NUM_BLANK : fmt_digit(disp_r_d);
      end
      SLOT_L: begin
        sel_d = blank_l ? SLOT_DARK : SLOT_L;
        num_d = blank_l ? NUM_BLANK : fmt_digit(disp_l_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_l_q <= 4'd0;
      disp_r_q <= 4'd0;
      pend_l_q <= 4'd0;
      pend_r_q <= 4'd0;
      pflag_q  <= 1'b0;
      mode_q   <= SHOW;
      win_l_q  <= 1'b0;
      hidden_q <= 1'b0;
      fc_q     <= '0;
      sel_q    <= 2'd0;
      num_q    <= 4'd0;
    end else begin
      disp_l_q <= disp_l_d;
      disp_r_q <= disp_r_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      pflag_q  <= pflag_d;
      mode_q   <= mode_d;
      win_l_q  <= win_l_d;
      hidden_q <= hidden_d;
      fc_q     <= fc_d;
      sel_q    <= sel_d;
      num_q    <= num_d;
    end
  end

  assign digit_sel  = sel_q;
  assign digit_num  = num_q;
  assign frame_tick = tick;

  logic unused_adv;
  assign unused_adv = slot_adv;

endmodule

// File: tb/tb_score_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_scan_ctrl
// Directed bench for score_scan_ctrl with SLOT_CYCLES = 4, BLINK_FRAMES = 2.
// A cycle-level reference model pushes the expected outputs for each clock
// into a queue; they are popped and compared one time unit after the edge.
// -----------------------------------------------------------------------------
module tb_score_scan_ctrl;
  import pong_disp_pkg::*;

  localparam int SC = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] score_l, score_r;
  logic       score_upd, game_over, winner_l, game_restart;
  logic [1:0] digit_sel;
  logic [3:0] digit_num;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  score_scan_ctrl #(
    .SLOT_CYCLES  (SC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .score_l      (score_l),
    .score_r      (score_r),
    .score_upd    (score_upd),
    .game_over    (game_over),
    .winner_l     (winner_l),
    .game_restart (game_restart),
    .digit_sel    (digit_sel),
    .digit_num    (digit_num),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] num;
    logic       tick;
  } exp_t;

  exp_t sb[$];

  // Reference model state (cycle index counted from reset release).
  int         mcyc;
  logic [3:0] m_dl, m_dr, m_pl, m_pr;
  bit         m_pf, m_blink, m_win, m_hid;
  int         m_fc;

  int tick_seen;
  bit seen_l5, seen_r5, seen_l6, seen_r8;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int slot_of(input int c);
    return (c / SC) % 4;
  endfunction

  function automatic bit tick_of(input int c);
    return (c > 0) && (c % (4 * SC) == 0);
  endfunction

  function automatic logic [3:0] shown(input logic [3:0] v);
    return (v > 4'd9) ? 4'hF : v;
  endfunction

  task automatic model_reset();
    mcyc = 0;
    m_dl = 0; m_dr = 0; m_pl = 0; m_pr = 0;
    m_pf = 0; m_blink = 0; m_win = 0; m_hid = 0; m_fc = 0;
  endtask

  task automatic step(input bit upd, input logic [3:0] l, input logic [3:0] r,
                      input bit go, input bit wl, input bit rs);
    exp_t e, o;
    bit   tk;
    int   s;
    bit   hide_l, hide_r;
    score_upd = upd; score_l = l; score_r = r;
    game_over = go; winner_l = wl; game_restart = rs;
    tk = tick_of(mcyc);
    s  = slot_of(mcyc);
    if (rs) begin
      m_dl = 0; m_dr = 0; m_pl = 0; m_pr = 0; m_pf = 0;
      m_blink = 0; m_hid = 0; m_fc = 0;
    end else begin
      if (tk && m_pf) begin
        m_dl = m_pl; m_dr = m_pr; m_pf = 0;
      end
      if (upd) begin
        m_pl = l; m_pr = r; m_pf = 1;
      end
      if (go) begin
        m_blink = 1; m_win = wl; m_hid = 0; m_fc = 0;
      end else if (m_blink && tk) begin
        if (m_fc == BF - 1) begin
          m_fc = 0; m_hid = !m_hid;
        end else begin
          m_fc++;
        end
      end
    end
    hide_l = m_blink && m_hid && m_win;
    hide_r = m_blink && m_hid && !m_win;
    if (s == 0) begin
      e.sel = hide_r ? 2'd1 : 2'd0;
      e.num = hide_r ? 4'hF : shown(m_dr);
    end else if (s == 2) begin
      e.sel = hide_l ? 2'd1 : 2'd2;
      e.num = hide_l ? 4'hF : shown(m_dl);
    end else begin
      e.sel = 2'(s);
      e.num = 4'hF;
    end
    e.tick = tick_of(mcyc + 1);
    sb.push_back(e);
    mcyc++;
    @(posedge clk);
    #1;
    score_upd = 0; game_over = 0; game_restart = 0;
    o = sb.pop_front();
    chk("digit_sel", int'(digit_sel), int'(o.sel));
    chk("digit_num", int'(digit_num), int'(o.num));
    chk("frame_tick", int'(frame_tick), int'(o.tick));
    if (frame_tick === 1'b1) tick_seen++;
    if (digit_sel === 2'd2 && digit_num === 4'd5) seen_l5 = 1;
    if (digit_sel === 2'd0 && digit_num === 4'd5) seen_r5 = 1;
    if (digit_sel === 2'd2 && digit_num === 4'd6) seen_l6 = 1;
    if (digit_sel === 2'd0 && digit_num === 4'd8) seen_r8 = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 4'd0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    score_l = 0; score_r = 0; score_upd = 0;
    game_over = 0; winner_l = 0; game_restart = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sel", int'(digit_sel), 0);
    chk("reset_num", int'(digit_num), 0);
    chk("reset_tick", int'(frame_tick), 0);
    reset = 1'b0;
    model_reset();

    // Free run: scan sequence and tick spacing.
    tick_seen = 0;
    idle(40);
    chk("tick_count_40", tick_seen, 2);

    // Mid-frame update appears only after the next frame boundary.
    step(1, 4'd3, 4'd7, 0, 0, 0);
    idle(24);

    // Two updates inside one frame: last one wins.
    seen_l5 = 0; seen_r5 = 0; seen_l6 = 0; seen_r8 = 0;
    step(1, 4'd5, 4'd5, 0, 0, 0);
    idle(2);
    step(1, 4'd6, 4'd8, 0, 0, 0);
    idle(36);
    chk("no_left_5", int'(seen_l5), 0);
    chk("no_right_5", int'(seen_r5), 0);
    chk("left_6_seen", int'(seen_l6), 1);
    chk("right_8_seen", int'(seen_r8), 1);

    // Out-of-range left score shows as a dash.
    step(1, 4'd12, 4'd9, 0, 0, 0);
    idle(36);

    // Left wins with 9/4: left digit blinks, right digit steady.
    step(1, 4'd9, 4'd4, 0, 0, 0);
    idle(20);
    step(0, 4'd0, 4'd0, 1, 1, 0);
    idle(80);

    // Restart beats a coincident update.
    step(1, 4'd2, 4'd2, 0, 0, 1);
    chk("restart_pflag", int'(dut.pflag_q), 0);
    chk("restart_mode", int'(dut.mode_q), int'(SHOW));
    idle(20);

    // Right wins, then a second game_over re-latches the left player.
    step(1, 4'd1, 4'd2, 0, 0, 0);
    idle(20);
    step(0, 4'd0, 4'd0, 1, 0, 0);
    idle(40);
    step(0, 4'd0, 4'd0, 1, 1, 0);
    idle(20);

    // Park in slot 1, post an update, move into mid slot 2, then reset.
    for (int i = 0; i < 20 && slot_of(mcyc) != 1; i++) idle(1);
    step(1, 4'd7, 4'd7, 0, 0, 0);
    for (int i = 0; i < 20 && !(slot_of(mcyc) == 2 && (mcyc % SC) == 1); i++) idle(1);
    chk("pending_before_reset", int'(dut.pflag_q), int'(m_pf));
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_sel", int'(digit_sel), 0);
    chk("async_rst_num", int'(digit_num), 0);
    chk("async_rst_tick", int'(frame_tick), 0);
    chk("async_rst_pflag", int'(dut.pflag_q), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    tick_seen = 0;
    idle(40);
    chk("tick_count_after_rst", tick_seen, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
